// File: rtl/rom_arb_pkg.sv
// Shared types for the two-port ROM read arbiter.
//   owner_e    : which requester a ROM read belongs to
//   inflight_t : {valid, owner} tag for the read issued last cycle
//   other_port : returns the port that is not the argument
package rom_arb_pkg;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } inflight_t;

  localparam inflight_t INFLIGHT_IDLE = '{valid: 1'b0, owner: PORT0};

  function automatic owner_e other_port(input owner_e o);
    return (o == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/rom_rsp_buf.sv
// One-entry response buffer with a same-cycle bypass.
// In the cycle a ROM word arrives (capture), the word is presented directly,
// so rsp_valid rises one cycle after the grant. If the requester does not
// take it in that cycle, the word is stored and held until rsp_ready.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   capture      : ROM data for this port is on cap_data this cycle
//   cap_data     : ROM read data
//   rsp_ready    : requester consumes the response
//   rsp_valid    : response available
//   rsp_data     : response word
//   full         : a word is stored (port must not be granted again)
module rom_rsp_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  rsp_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  full
);

  logic                  full_q;
  logic [DATA_WIDTH-1:0] data_q;

  // capture and full_q are never both high: the arbiter does not grant a
  // port whose buffer is occupied.
  assign rsp_valid = full_q | capture;
  assign rsp_data  = (capture && !full_q) ? cap_data : data_q;
  assign full      = full_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (capture && !full_q && !rsp_ready) begin
      full_q <= 1'b1;
      data_q <= cap_data;
    end else if (full_q && rsp_ready) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_arbiter2.sv
// Two-requester round-robin arbiter in front of a synchronous single-port ROM.
// One read per cycle at most; response returns one cycle after the grant
// through a per-port one-entry buffer.
// Ports:
//   clk, reset_n              : clock, async active-low reset
//   reqN_valid/addr/ready     : request handshake for port N
//   rspN_valid/data/ready     : response handshake for port N
//   rom_ce, rom_addr          : ROM read strobe and address
//   rom_dout                  : ROM data, valid the cycle after rom_ce
module rom_arbiter2
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  input  logic                  rsp1_ready,
  output logic                  rom_ce,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  inflight_t             inflight_q;
  owner_e                ptr_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic   full0, full1;
  logic   capture0, capture1;
  logic   elig0, elig1;
  logic   grant_vld;
  owner_e grant_owner;

  assign capture0 = inflight_q.valid && (inflight_q.owner == PORT0);
  assign capture1 = inflight_q.valid && (inflight_q.owner == PORT1);

  // reset_n gates eligibility so that no ready/ce escapes while in reset.
  assign elig0 = reset_n && req0_valid && !full0 && !capture0;
  assign elig1 = reset_n && req1_valid && !full1 && !capture1;

  always_comb begin
    grant_vld   = 1'b0;
    grant_owner = ptr_q;
    if (elig0 && elig1) begin
      grant_vld   = 1'b1;
      grant_owner = ptr_q;
    end else if (elig0) begin
      grant_vld   = 1'b1;
      grant_owner = PORT0;
    end else if (elig1) begin
      grant_vld   = 1'b1;
      grant_owner = PORT1;
    end
  end

  assign req0_ready = grant_vld && (grant_owner == PORT0);
  assign req1_ready = grant_vld && (grant_owner == PORT1);
  assign rom_ce     = grant_vld;

  // Address holds its last issued value while idle to avoid toggling.
  always_comb begin
    rom_addr = addr_q;
    if (grant_vld) begin
      rom_addr = (grant_owner == PORT0) ? req0_addr : req1_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= INFLIGHT_IDLE;
      ptr_q      <= PORT0;
      addr_q     <= '0;
    end else begin
      inflight_q <= '{valid: grant_vld, owner: grant_owner};
      addr_q     <= rom_addr;
      if (grant_vld) begin
        ptr_q <= other_port(grant_owner);
      end
    end
  end

  rom_rsp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture0),
    .cap_data  (rom_dout),
    .rsp_ready (rsp0_ready),
    .rsp_valid (rsp0_valid),
    .rsp_data  (rsp0_data),
    .full      (full0)
  );

  rom_rsp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture1),
    .cap_data  (rom_dout),
    .rsp_ready (rsp1_ready),
    .rsp_valid (rsp1_valid),
    .rsp_data  (rsp1_data),
    .full      (full1)
  );

endmodule
